// File: rtl/sd_cmd_pkg.sv
// Shared types and constants for the SD CMD-line engine.
package sd_cmd_pkg;

  typedef enum logic [1:0] {
    NO_RESPONSE     = 2'd0,
    LONG_RESPONSE   = 2'd1,
    NORMAL_RESPONSE = 2'd2,
    AUTO_CMD52      = 2'd3
  } resp_type_e;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    TURNAROUND,
    WAIT_START,
    RECEIVE,
    NRC,
    DONE
  } cmd_state_e;

  // x^7 + x^3 + 1 (x^7 implicit)
  localparam logic [6:0] CRC7_POLY = 7'h09;

  localparam int unsigned SHORT_FRAME_LEN = 48;
  localparam int unsigned LONG_FRAME_LEN  = 136;

endpackage

// File: rtl/sd_cmd_phy_crc7.sv
// Serial CRC7 generator, one bit per enabled cycle, MSB-first data.
import sd_cmd_pkg::*;

module sd_crc7 (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       data_in,
  output logic [6:0] crc
);

  logic feedback;

  assign feedback = data_in ^ crc[6];

  // LFSR update; clear wins over enable
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      crc <= '0;
    end else if (enable) begin
      crc <= {crc[5:0], 1'b0} ^ (feedback ? CRC7_POLY : '0);
    end
  end

endmodule

// File: rtl/sd_cmd_phy.sv
// SD host CMD-line engine: frames and sends a 48-bit command with CRC7,
// then waits for and deserialises a 48/136-bit response.
// Optional macro SD_CMD_CRC_CHECK_EN builds the receive CRC7 check.
import sd_cmd_pkg::*;

module sd_cmd_phy #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned NRC_CYCLES     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         emmit_command,
  input  logic [5:0]   command_index,
  input  logic [31:0]  argument,
  input  logic [1:0]   response_type,
  input  logic         cmd_in,
  output logic         cmd_out,
  output logic         cmd_oe,
  output logic [135:0] response,
  output logic         command_complete,
  output logic         timeout_error,
  output logic         crc_error,
  output logic         busy
);

  localparam logic [7:0] LAST_TX    = 8'(SHORT_FRAME_LEN - 1);
  localparam logic [7:0] LAST_SHORT = 8'(SHORT_FRAME_LEN - 1);
  localparam logic [7:0] LAST_LONG  = 8'(LONG_FRAME_LEN - 1);

  cmd_state_e  state, state_next;
  resp_type_e  type_q;
  logic        edge_q;
  logic        wait_low;
  logic        start;
  logic        long_q;
  logic [39:0] tx_shift;
  logic [7:0]  bit_cnt;
  logic [31:0] wait_cnt;
  logic [7:0]  last_rx;
  logic [6:0]  tx_crc;
  logic        tx_crc_en;
  logic        tx_bit;

  // wait_low blocks a start until emmit_command has been seen low after
  // reset, so a request held high across reset is not mistaken for an edge
  assign start     = (state == IDLE) && emmit_command && !edge_q && !wait_low;
  assign long_q    = (type_q == LONG_RESPONSE);
  assign last_rx   = long_q ? LAST_LONG : LAST_SHORT;
  assign tx_crc_en = (state == SEND) && (bit_cnt < 8'd40);

  sd_crc7 tx_crc_gen (
    .clock   (clock),
    .reset   (reset),
    .clear   (start),
    .enable  (tx_crc_en),
    .data_in (tx_shift[39]),
    .crc     (tx_crc)
  );

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:       if (start) state_next = SEND;
      SEND:       if (bit_cnt == LAST_TX)
                    state_next = (type_q == NO_RESPONSE) ? NRC : TURNAROUND;
      TURNAROUND: if (bit_cnt == 8'd1) state_next = WAIT_START;
      WAIT_START: begin
        if (!cmd_in)                          state_next = RECEIVE;
        else if (wait_cnt == TIMEOUT_CYCLES)  state_next = DONE;
      end
      RECEIVE:    if (bit_cnt == last_rx) state_next = DONE;
      NRC:        if (wait_cnt == NRC_CYCLES) state_next = DONE;
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  // transmit bit: header/argument, then CRC7 MSB first, then end bit
  always_comb begin
    tx_bit = 1'b1;
    if (bit_cnt < 8'd40)      tx_bit = tx_shift[39];
    else if (bit_cnt < 8'd47) tx_bit = tx_crc[3'(8'd46 - bit_cnt)];
  end

  // FSM outputs
  always_comb begin
    cmd_oe           = 1'b0;
    cmd_out          = 1'b1;
    busy             = 1'b1;
    command_complete = 1'b0;
    unique case (state)
      IDLE:    busy = 1'b0;
      SEND:    begin cmd_oe = 1'b1; cmd_out = tx_bit; end
      NRC:     cmd_oe = 1'b1;
      DONE:    command_complete = 1'b1;
      default: ;
    endcase
  end

  // datapath: capture, shifting, counters and result flags
  always_ff @(posedge clock) begin
    if (reset) begin
      edge_q        <= 1'b0;
      wait_low      <= 1'b1;
      type_q        <= NO_RESPONSE;
      tx_shift      <= '0;
      bit_cnt       <= '0;
      wait_cnt      <= '0;
      response      <= '0;
      timeout_error <= 1'b0;
    end else begin
      edge_q <= emmit_command;
      if (!emmit_command) wait_low <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            type_q        <= resp_type_e'(response_type);
            tx_shift      <= {1'b0, 1'b1, command_index, argument};
            bit_cnt       <= '0;
            response      <= '0;
            timeout_error <= 1'b0;
          end
        end
        SEND: begin
          tx_shift <= {tx_shift[38:0], 1'b0};
          bit_cnt  <= (bit_cnt == LAST_TX) ? '0 : bit_cnt + 8'd1;
          wait_cnt <= 32'd1;
        end
        TURNAROUND: begin
          bit_cnt  <= bit_cnt + 8'd1;
          wait_cnt <= 32'd1;
        end
        WAIT_START: begin
          if (!cmd_in) begin
            response <= {response[134:0], cmd_in};
            bit_cnt  <= 8'd1;
          end else if (wait_cnt == TIMEOUT_CYCLES) begin
            timeout_error <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end
        RECEIVE: begin
          response <= {response[134:0], cmd_in};
          bit_cnt  <= bit_cnt + 8'd1;
        end
        NRC:     wait_cnt <= wait_cnt + 32'd1;
        default: ;
      endcase
    end
  end

`ifdef SD_CMD_CRC_CHECK_EN
  logic [6:0] rx_crc;
  logic       rx_crc_en;

  // start bit is frame position 0; short frames cover positions 0..39,
  // long frames skip the 8-bit header and cover positions 8..127
  assign rx_crc_en =
      ((state == WAIT_START) && !cmd_in && !long_q) ||
      ((state == RECEIVE) &&
       (long_q ? ((bit_cnt >= 8'd8) && (bit_cnt < 8'd128)) : (bit_cnt < 8'd40)));

  sd_crc7 rx_crc_gen (
    .clock   (clock),
    .reset   (reset),
    .clear   (start),
    .enable  (rx_crc_en),
    .data_in (cmd_in),
    .crc     (rx_crc)
  );

  // on the end-bit cycle the received CRC field sits in response[6:0]
  always_ff @(posedge clock) begin
    if (reset) begin
      crc_error <= 1'b0;
    end else if (start) begin
      crc_error <= 1'b0;
    end else if ((state == RECEIVE) && (bit_cnt == last_rx)) begin
      crc_error <= (response[6:0] != rx_crc);
    end
  end
`else
  assign crc_error = 1'b0;
`endif

endmodule

// File: tb/tb_sd_cmd_phy.sv
// Directed bench for sd_cmd_phy: command framing, response capture,
// timeout, CRC checking and reset behaviour.
module tb_sd_cmd_phy;

  localparam int unsigned TIMEOUT = 64;
  localparam int unsigned NRC     = 8;

`ifdef SD_CMD_CRC_CHECK_EN
  localparam logic EXP_BAD_CRC = 1'b1;
`else
  localparam logic EXP_BAD_CRC = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic         emmit_command;
  logic [5:0]   command_index;
  logic [31:0]  argument;
  logic [1:0]   response_type;
  logic         cmd_in;
  logic         cmd_out;
  logic         cmd_oe;
  logic [135:0] response;
  logic         command_complete;
  logic         timeout_error;
  logic         crc_error;
  logic         busy;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clock = ~clock;

  sd_cmd_phy #(.TIMEOUT_CYCLES(TIMEOUT), .NRC_CYCLES(NRC)) dut (
    .clock            (clock),
    .reset            (reset),
    .emmit_command    (emmit_command),
    .command_index    (command_index),
    .argument         (argument),
    .response_type    (response_type),
    .cmd_in           (cmd_in),
    .cmd_out          (cmd_out),
    .cmd_oe           (cmd_oe),
    .response         (response),
    .command_complete (command_complete),
    .timeout_error    (timeout_error),
    .crc_error        (crc_error),
    .busy             (busy)
  );

  task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] crc7_range(input logic [135:0] v, input int hi, input int lo);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = hi; i >= lo; i--) begin
      fb = v[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  // Runs one command. View k is the negedge before edge Tk; cmd_in set
  // there is what the DUT samples at Tk. Reply start bit lands at T(51+gap).
  task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg,
                        input logic [1:0] rtype, input logic [135:0] reply,
                        input int reply_len, input int gap,
                        output logic [47:0] line, output int done_at,
                        output int oe_err, output logic busy_t1,
                        output logic busy_after, output logic cc_after);
    int  ts;
    logic exp_oe;
    @(negedge clock);
    emmit_command = 1'b0;
    cmd_in        = 1'b1;
    @(negedge clock);
    command_index = idx;
    argument      = arg;
    response_type = rtype;
    emmit_command = 1'b1;
    @(posedge clock);
    line = '0; done_at = -1; oe_err = 0;
    busy_t1 = 1'b0; busy_after = 1'b1; cc_after = 1'b1;
    ts = 51 + gap;
    for (int k = 1; k <= 400 && done_at < 0; k++) begin
      @(negedge clock);
      if (k == 3) emmit_command = 1'b0;
      if (reply_len > 0 && k >= ts && k < ts + reply_len)
        cmd_in = reply[reply_len - 1 - (k - ts)];
      else
        cmd_in = 1'b1;
      if (k == 1) busy_t1 = busy;
      if (k <= 48) line[48 - k] = cmd_out;
      exp_oe = (k <= 48) || (rtype == 2'd0 && k <= 48 + int'(NRC));
      if (cmd_oe !== exp_oe || (!cmd_oe && cmd_out !== 1'b1)) oe_err++;
      if (command_complete === 1'b1) done_at = k;
    end
    if (done_at >= 0) begin
      @(negedge clock);
      busy_after = busy;
      cc_after   = command_complete;
    end
    cmd_in = 1'b1;
  endtask

  logic [47:0]  line;
  int           done_at, oe_err;
  logic         busy_t1, busy_after, cc_after;
  logic [135:0] long_frame;
  logic         cc_seen, busy_seen;

  initial begin
    reset = 1'b1; emmit_command = 1'b0; command_index = '0;
    argument = '0; response_type = '0; cmd_in = 1'b1;
    repeat (3) @(negedge clock);
    check_eq("rst_cmd_oe", cmd_oe, 1'b0);
    check_eq("rst_cmd_out", cmd_out, 1'b1);
    check_eq("rst_response", response, '0);
    check_eq("rst_flags", {command_complete, timeout_error, crc_error, busy}, 4'b0000);
    reset = 1'b0;

    // CMD0, no response
    do_cmd(6'd0, 32'h0, 2'd0, '0, 0, 0, line, done_at, oe_err, busy_t1, busy_after, cc_after);
    check_eq("cmd0_line", line, 48'h40_00000000_95);
    check_eq("cmd0_done_at", done_at, 57);
    check_eq("cmd0_oe_pattern", oe_err, 0);
    check_eq("cmd0_busy_t1", busy_t1, 1'b1);
    check_eq("cmd0_after", {busy_after, cc_after}, 2'b00);
    check_eq("cmd0_errors", {timeout_error, crc_error}, 2'b00);

    // CMD8 with a good R7 reply after 5 idle cycles
    do_cmd(6'd8, 32'h1AA, 2'd2, 136'h08_000001AA_13, 48, 5, line, done_at, oe_err, busy_t1, busy_after, cc_after);
    check_eq("cmd8_line", line, 48'h48_000001AA_87);
    check_eq("cmd8_done_at", done_at, 56 + 48);
    check_eq("cmd8_response", response, 136'h08_000001AA_13);
    check_eq("cmd8_errors", {timeout_error, crc_error}, 2'b00);
    check_eq("cmd8_oe_pattern", oe_err, 0);

    // same exchange, corrupted CRC byte
    do_cmd(6'd8, 32'h1AA, 2'd2, 136'h08_000001AA_15, 48, 5, line, done_at, oe_err, busy_t1, busy_after, cc_after);
    check_eq("badcrc_response", response, 136'h08_000001AA_15);
    check_eq("badcrc_flag", crc_error, EXP_BAD_CRC);
    check_eq("badcrc_done_at", done_at, 104);

    // no start bit: timeout
    do_cmd(6'd8, 32'h1AA, 2'd2, '0, 0, 0, line, done_at, oe_err, busy_t1, busy_after, cc_after);
    check_eq("timeout_done_at", done_at, 51 + int'(TIMEOUT));
    check_eq("timeout_flags", {timeout_error, crc_error}, 2'b10);
    check_eq("timeout_response", response, '0);

    // CMD2 with a long R2 reply carrying a valid CRC
    long_frame = {8'h3F, 120'h1D41_4453_4430_3030_1012_3456_7801_A5, 7'h00, 1'b1};
    long_frame[7:1] = crc7_range(long_frame, 127, 8);
    do_cmd(6'd2, 32'h0, 2'd1, long_frame, 136, 2, line, done_at, oe_err, busy_t1, busy_after, cc_after);
    check_eq("cmd2_line", line, 48'h42_00000000_4D);
    check_eq("cmd2_done_at", done_at, 53 + 136);
    check_eq("cmd2_response", response, long_frame);
    check_eq("cmd2_errors", {timeout_error, crc_error}, 2'b00);

    // reset during SEND with the request held high throughout
    @(negedge clock);
    emmit_command = 1'b0;
    @(negedge clock);
    command_index = 6'd0; argument = '0; response_type = 2'd0;
    emmit_command = 1'b1;
    @(posedge clock);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      if (k == 20) reset = 1'b1;
    end
    @(negedge clock);
    check_eq("rst_mid_oe", {cmd_oe, cmd_out, busy}, 3'b010);
    reset = 1'b0;
    cc_seen = 1'b0; busy_seen = 1'b0;
    repeat (80) begin
      @(negedge clock);
      cc_seen   = cc_seen | command_complete;
      busy_seen = busy_seen | busy;
    end
    check_eq("held_high_no_restart", {busy_seen, cc_seen}, 2'b00);

    do_cmd(6'd0, 32'h0, 2'd0, '0, 0, 0, line, done_at, oe_err, busy_t1, busy_after, cc_after);
    check_eq("fresh_edge_busy", busy_t1, 1'b1);
    check_eq("fresh_edge_done_at", done_at, 57);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
